// File: rtl/vga_frame_sequencer_pkg.sv
// Package for the VGA frame sequencer.
// Holds the 640x480@60 timing constants, the counter and miss-counter widths,
// the update FSM state encoding, and a small window-compare helper.
// Modules use the timing constants as parameter defaults. The sync window
// bounds are derived from those parameters, so a scaled geometry stays
// consistent.
package vga_frame_sequencer_pkg;

   localparam int CNT_W  = 10;
   localparam int MISS_W = 8;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   typedef enum logic [1:0] {
      ST_SCAN = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } upd_state_e;

   // Inclusive range test used for the sync pulse windows.
   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Scan position counter for the VGA frame sequencer.
// X advances every clock and wraps at HTOT-1. Y advances when X wraps, and Y
// itself wraps at VTOT-1 on that same edge. The next-state values are exported
// so that the parent can register its decode in the same cycle as the counters.
// Ports:
//   clk       pixel clock
//   reset     synchronous, active-low; parks the counters at the last position
//   x_o/y_o   current column/row (registered)
//   x_next_o  value X takes on the next edge
//   y_next_o  value Y takes on the next edge
module vga_scan_counter
   import vga_frame_sequencer_pkg::*;
#(
   parameter int HTOT = 800,
   parameter int VTOT = 525
)(
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic [CNT_W-1:0] x_next_o,
   output logic [CNT_W-1:0] y_next_o
);

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(HTOT - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(VTOT - 1);

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q + CNT_W'(1);
      y_d = y_q;
      if (x_q == X_LAST) begin
         x_d = '0;
         y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
      end
   end

   // Parking at the last position makes the first edge after reset land on (0,0).
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q <= X_LAST;
         y_q <= Y_LAST;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o      = x_q;
   assign y_o      = y_q;
   assign x_next_o = x_d;
   assign y_next_o = y_d;

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA frame sequencer.
// This module produces the scan position, the sync and blanking outputs, and a
// once-per-frame game update handshake.
// An update request opens at the start of vertical blanking. The game logic
// acknowledges it with upd_ack. If no acknowledge arrives by the last line, the
// update is recorded as missed. A completed update is committed with the next
// frame_start.
// Ports:
//   clk, reset        pixel clock; synchronous active-low reset
//   upd_ack           game logic finished its update (pulse or level)
//   CounterX/Y        scan position
//   hsync/vsync       active-low sync pulses
//   in_display        visible-area flag
//   frame_start       one-cycle pulse at (0,0)
//   upd_req           update request, high while waiting for upd_ack
//   commit            one-cycle pulse with frame_start after a completed update
//   upd_missed        one-cycle pulse when the deadline passes without upd_ack
//   miss_count        saturating count of missed updates
module vga_frame_sequencer
   import vga_frame_sequencer_pkg::*;
#(
   parameter int HACT  = H_ACTIVE,
   parameter int HFP   = H_FP,
   parameter int HSYNC = H_SYNC,
   parameter int HBP   = H_BP,
   parameter int VACT  = V_ACTIVE,
   parameter int VFP   = V_FP,
   parameter int VSYNC = V_SYNC,
   parameter int VBP   = V_BP
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              upd_ack,
   output logic [CNT_W-1:0]  CounterX,
   output logic [CNT_W-1:0]  CounterY,
   output logic              hsync,
   output logic              vsync,
   output logic              in_display,
   output logic              frame_start,
   output logic              upd_req,
   output logic              commit,
   output logic              upd_missed,
   output logic [MISS_W-1:0] miss_count
);

   localparam int HTOT = HACT + HFP + HSYNC + HBP;
   localparam int VTOT = VACT + VFP + VSYNC + VBP;

   localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(HACT + HFP);
   localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(HACT + HFP + HSYNC - 1);
   localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(VACT + VFP);
   localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(VACT + VFP + VSYNC - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(HACT);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(VACT);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VTOT - 1);

   logic [CNT_W-1:0] x_next, y_next;

   vga_scan_counter #(
      .HTOT (HTOT),
      .VTOT (VTOT)
   ) u_scan (
      .clk      (clk),
      .reset    (reset),
      .x_o      (CounterX),
      .y_o      (CounterY),
      .x_next_o (x_next),
      .y_next_o (y_next)
   );

   // Edge markers, all taken from the position the counters are about to take.
   logic at_frame, at_req, at_deadline;
   assign at_frame    = (x_next == '0) && (y_next == '0);
   assign at_req      = (x_next == '0) && (y_next == V_ACT_C);
   assign at_deadline = (x_next == '0) && (y_next == V_LAST);

   upd_state_e        state_q, state_d;
   logic              hsync_q, vsync_q, in_display_q, frame_start_q;
   logic              upd_req_q, upd_req_d;
   logic              commit_q, commit_d;
   logic              upd_missed_q, upd_missed_d;
   logic [MISS_W-1:0] miss_count_q, miss_count_d;

   always_comb begin
      state_d      = state_q;
      upd_req_d    = upd_req_q;
      commit_d     = 1'b0;
      upd_missed_d = 1'b0;
      miss_count_d = miss_count_q;
      case (state_q)
         ST_SCAN: begin
            if (at_req) begin
               state_d   = ST_REQ;
               upd_req_d = 1'b1;
            end
         end
         ST_REQ: begin
            // An acknowledge on the deadline edge still counts as on time.
            if (upd_ack) begin
               state_d   = ST_DONE;
               upd_req_d = 1'b0;
            end else if (at_deadline) begin
               state_d      = ST_SCAN;
               upd_req_d    = 1'b0;
               upd_missed_d = 1'b1;
               if (miss_count_q != '1)
                  miss_count_d = miss_count_q + MISS_W'(1);
            end
         end
         ST_DONE: begin
            if (at_frame) begin
               state_d  = ST_SCAN;
               commit_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_SCAN;
            upd_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_SCAN;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         in_display_q  <= 1'b0;
         frame_start_q <= 1'b0;
         upd_req_q     <= 1'b0;
         commit_q      <= 1'b0;
         upd_missed_q  <= 1'b0;
         miss_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         hsync_q       <= !in_window(x_next, HS_LO, HS_HI);
         vsync_q       <= !in_window(y_next, VS_LO, VS_HI);
         in_display_q  <= (x_next < H_ACT_C) && (y_next < V_ACT_C);
         frame_start_q <= at_frame;
         upd_req_q     <= upd_req_d;
         commit_q      <= commit_d;
         upd_missed_q  <= upd_missed_d;
         miss_count_q  <= miss_count_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign in_display  = in_display_q;
   assign frame_start = frame_start_q;
   assign upd_req     = upd_req_q;
   assign commit      = commit_q;
   assign upd_missed  = upd_missed_q;
   assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Testbench for vga_frame_sequencer.
// Two instances are used. The first runs the full 640x480 geometry and is
// checked only over reset and the first line and a bit. The second uses a
// scaled geometry (16x12 total, 8x6 visible) so that hundreds of frames fit in
// a short run.
// Scaled geometry: hsync window X 10..13, vsync window Y 7..8, request at
// (0,6), deadline at (0,11), frame length 192 cycles.
// Scoreboard events are frame_start, upd_missed, and any change of upd_req.
module tb_vga_frame_sequencer;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       fs;
      logic       commit;
      logic       req;
      logic       missed;
      logic [7:0] miss;
   } ev_t;

   logic clk;
   logic rst_n, rst_big_n;
   logic ack, ack_big;

   logic [9:0] bx, by;
   logic       bhs, bvs, bdisp, bfs, breq, bcommit, bmissed;
   logic [7:0] bmiss;

   logic [9:0] sx, sy;
   logic       shs, svs, sdisp, sfs, sreq, scommit, smissed;
   logic [7:0] smiss;

   int  errors = 0;
   int  checks = 0;
   ev_t exp_q[$];

   vga_frame_sequencer u_big (
      .clk(clk), .reset(rst_big_n), .upd_ack(ack_big),
      .CounterX(bx), .CounterY(by), .hsync(bhs), .vsync(bvs),
      .in_display(bdisp), .frame_start(bfs), .upd_req(breq),
      .commit(bcommit), .upd_missed(bmissed), .miss_count(bmiss)
   );

   vga_frame_sequencer #(
      .HACT(8), .HFP(2), .HSYNC(4), .HBP(2),
      .VACT(6), .VFP(1), .VSYNC(2), .VBP(3)
   ) u_small (
      .clk(clk), .reset(rst_n), .upd_ack(ack),
      .CounterX(sx), .CounterY(sy), .hsync(shs), .vsync(svs),
      .in_display(sdisp), .frame_start(sfs), .upd_req(sreq),
      .commit(scommit), .upd_missed(smissed), .miss_count(smiss)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_ev(input int x, input int y, input bit fs, input bit cm,
                          input bit rq, input bit ms, input int miss);
      ev_t e;
      e.x = 10'(x); e.y = 10'(y); e.fs = fs; e.commit = cm;
      e.req = rq; e.missed = ms; e.miss = 8'(miss);
      exp_q.push_back(e);
   endtask

   // Always steps at least one cycle, then waits until the small instance sits at (x,y).
   task automatic wait_xy(input int x, input int y, input string what);
      int n = 0;
      @(negedge clk);
      while (!(sx == 10'(x) && sy == 10'(y))) begin
         @(negedge clk);
         n++;
         if (n > 1000) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: position (%0d,%0d) not reached, at (%0d,%0d)", what, x, y, sx, sy);
            return;
         end
      end
   endtask

   task automatic chk_reset_small(input string tag);
      chk({tag, "_x"}, sx, 15);      chk({tag, "_y"}, sy, 11);
      chk({tag, "_hsync"}, shs, 1);  chk({tag, "_vsync"}, svs, 1);
      chk({tag, "_disp"}, sdisp, 0); chk({tag, "_fs"}, sfs, 0);
      chk({tag, "_req"}, sreq, 0);   chk({tag, "_commit"}, scommit, 0);
      chk({tag, "_missed"}, smissed, 0); chk({tag, "_miss"}, smiss, 0);
   endtask

   initial begin
      int m;
      rst_n = 1'b0; rst_big_n = 1'b0; ack = 1'b0; ack_big = 1'b0;

      // Frame 1 after release.
      push_ev(0, 0, 1, 0, 0, 0, 0);
      // A: ack 10 cycles after the request; the request drops at (10,6).
      push_ev(0, 6, 0, 0, 1, 0, 0); push_ev(10, 6, 0, 0, 0, 0, 0); push_ev(0, 0, 1, 1, 0, 0, 0);
      // B: no ack; miss at the deadline and no commit afterwards.
      push_ev(0, 6, 0, 0, 1, 0, 0); push_ev(0, 11, 0, 0, 0, 1, 1); push_ev(0, 0, 1, 0, 0, 0, 1);
      // C: ack on the deadline edge wins.
      push_ev(0, 6, 0, 0, 1, 0, 1); push_ev(0, 11, 0, 0, 0, 0, 1); push_ev(0, 0, 1, 1, 0, 0, 1);
      // D: 260 consecutive misses; the count saturates at 255.
      m = 1;
      for (int i = 0; i < 260; i++) begin
         push_ev(0, 6, 0, 0, 1, 0, m);
         m = (m < 255) ? m + 1 : 255;
         push_ev(0, 11, 0, 0, 0, 1, m);
         push_ev(0, 0, 1, 0, 0, 0, m);
      end
      // E: reset in the middle of REQ, then one missed frame from a clean count.
      push_ev(0, 6, 0, 0, 1, 0, 255); push_ev(15, 11, 0, 0, 0, 0, 0);
      push_ev(0, 0, 1, 0, 0, 0, 0);
      push_ev(0, 6, 0, 0, 1, 0, 0); push_ev(0, 11, 0, 0, 0, 1, 1); push_ev(0, 0, 1, 0, 0, 0, 1);

      fork
         begin : monitor
            logic prev_req = 1'b0, prev_pulse = 1'b0, acc_valid = 1'b0;
            int   hs_n = 0, hs_bad = 0, vs_n = 0, vs_start = -1, disp_n = 0, ev_n = 0;
            ev_t  obs, e;
            forever begin
               @(negedge clk);
               obs.x = sx; obs.y = sy; obs.fs = sfs; obs.commit = scommit;
               obs.req = sreq; obs.missed = smissed; obs.miss = smiss;
               if (sfs || smissed || (sreq != prev_req)) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL sb_unexpected: event at (%0d,%0d) fs=%0b req=%0b missed=%0b with empty queue",
                              sx, sy, sfs, sreq, smissed);
                  end else begin
                     e = exp_q.pop_front();
                     if (obs !== e) begin
                        errors++;
                        $display("FAIL sb_event %0d: got x=%0d y=%0d fs=%0b commit=%0b req=%0b missed=%0b miss=%0d, expected x=%0d y=%0d fs=%0b commit=%0b req=%0b missed=%0b miss=%0d",
                                 ev_n, obs.x, obs.y, obs.fs, obs.commit, obs.req, obs.missed, obs.miss,
                                 e.x, e.y, e.fs, e.commit, e.req, e.missed, e.miss);
                     end else
                        $display("event %0d at (%0d,%0d) fs=%0b commit=%0b req=%0b missed=%0b miss=%0d ok",
                                 ev_n, obs.x, obs.y, obs.fs, obs.commit, obs.req, obs.missed, obs.miss);
                  end
                  ev_n++;
               end
               if (prev_pulse) chk("pulse_width", int'({sfs, scommit, smissed}), 0);
               prev_req   = sreq;
               prev_pulse = sfs | scommit | smissed;

               if (!rst_n) begin
                  acc_valid = 1'b0;
                  hs_n = 0; hs_bad = 0; vs_n = 0; vs_start = -1; disp_n = 0;
               end else begin
                  if (sfs) begin
                     if (acc_valid) begin
                        chk("frame_hsync_low", hs_n, 48);
                        chk("frame_hsync_outside", hs_bad, 0);
                        chk("frame_vsync_low", vs_n, 32);
                        chk("frame_vsync_start_x100_y", vs_start, 7);
                        chk("frame_in_display", disp_n, 48);
                     end
                     acc_valid = 1'b1;
                     hs_n = 0; hs_bad = 0; vs_n = 0; vs_start = -1; disp_n = 0;
                  end
                  if (!shs) begin
                     hs_n++;
                     if (sx < 10 || sx > 13) hs_bad++;
                  end
                  if (!svs) begin
                     if (vs_n == 0) vs_start = int'(sx) * 100 + int'(sy);
                     vs_n++;
                  end
                  if (sdisp) disp_n++;
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk_reset_small("rst0");
      chk("big_rst_x", bx, 799);   chk("big_rst_y", by, 524);
      chk("big_rst_hsync", bhs, 1); chk("big_rst_vsync", bvs, 1);
      chk("big_rst_fs", bfs, 0);   chk("big_rst_disp", bdisp, 0);

      // Full geometry: first line and the start of the second.
      rst_big_n = 1'b1;
      for (int c = 1; c <= 801; c++) begin
         int ex, ey;
         @(negedge clk);
         ex = (c - 1) % 800;
         ey = (c - 1) / 800;
         chk("big_xy", int'(bx) * 1000 + int'(by), ex * 1000 + ey);
         if (c == 1) begin
            chk("big_c1_fs", bfs, 1);       chk("big_c1_disp", bdisp, 1);
            chk("big_c1_hsync", bhs, 1);    chk("big_c1_vsync", bvs, 1);
            chk("big_c1_commit", bcommit, 0);
         end
         if (c == 2)   chk("big_c2_fs", bfs, 0);
         if (ex == 639) chk("big_disp_x639", bdisp, 1);
         if (ex == 640) chk("big_disp_x640", bdisp, 0);
         if (ex == 655) chk("big_hsync_x655", bhs, 1);
         if (ex == 656) chk("big_hsync_x656", bhs, 0);
         if (ex == 751) chk("big_hsync_x751", bhs, 0);
         if (ex == 752) chk("big_hsync_x752", bhs, 1);
         if (c == 801) begin
            chk("big_line2_fs", bfs, 0);
            chk("big_line2_vsync", bvs, 1);
         end
      end

      // Scaled instance scenarios.
      rst_n = 1'b1;
      // A
      wait_xy(0, 6, "A_req");
      repeat (9) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      wait_xy(0, 0, "A_frame");
      // B
      wait_xy(0, 0, "B_frame");
      // C: a stray ack in SCAN is ignored, then ack lands on the deadline edge.
      wait_xy(3, 2, "C_stray");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      wait_xy(15, 10, "C_deadline");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      wait_xy(0, 0, "C_frame");
      // D
      for (int i = 0; i < 260; i++) wait_xy(0, 0, "D_frame");
      // E
      wait_xy(5, 8, "E_midreq");
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_small("rst_midreq");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_xy(0, 0, "E_frame1");
      wait_xy(0, 0, "E_frame2");

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      chk("sb_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
